instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 86 ++++++++
 tb/tb_instr_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, combinational instruction-memory port
// and a single registered fetch bundle handed to decode with a valid/ready handshake.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        fetch_err,
  output logic        halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [31:0] DEPTH_WORDS = IMEM_DEPTH;

  state_t      state;
  logic [31:0] pc;
  logic        slot_free;
  logic        transfer;
  logic        out_of_range;

  assign imem_addr    = {2'b00, pc[31:2]};
  assign transfer     = id_valid && id_ready;
  assign slot_free    = !id_valid || id_ready;
  assign out_of_range = imem_addr >= DEPTH_WORDS;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      id_valid  <= 1'b0;
      id_instr  <= '0;
      id_pc     <= '0;
      fetch_err <= 1'b0;
      halted    <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      unique case (state)
        BOOT: begin
          state  <= RUN;
          halted <= 1'b0;
        end
        RUN, HALT: begin
          if (redirect_valid) begin
            // Redirect flushes the held bundle even if decode is stalled.
            state     <= RUN;
            pc        <= {redirect_pc[31:2], 2'b00};
            id_valid  <= 1'b0;
            fetch_err <= |redirect_pc[1:0];
            halted    <= 1'b0;
          end else if (state == HALT || halt_req) begin
            if (transfer) id_valid <= 1'b0;
            if (halt_req) begin
              state  <= HALT;
              halted <= !(id_valid && !id_ready);
            end else begin
              state  <= RUN;
              halted <= 1'b0;
            end
          end else if (slot_free) begin
            id_valid  <= 1'b1;
            id_pc     <= pc;
            id_instr  <= out_of_range ? NOP_INSTR : imem_data;
            fetch_err <= out_of_range;
            pc        <= pc + 32'd4;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a transaction-level model of the fetch stage is
// compared every cycle, plus literal expectations at the interesting points.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        fetch_err;
  logic        halted;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  assign imem_data = (imem_addr < 32'd64) ? mem[imem_addr[5:0]] : 32'hDEAD_BEEF;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .fetch_err(fetch_err), .halted(halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected word at a byte address: the program image or the NOP filler.
  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return (addr >> 2) < 32'd64 ? 32'h1000_0000 + (addr >> 2) : 32'h0000_0013;
  endfunction

  // Model: a held bundle first drains if decode takes it, then an empty slot refills.
  typedef enum {M_BOOT, M_RUN, M_HALT} mode_t;
  mode_t       m_mode;
  logic [31:0] m_pc, m_bpc, m_binstr;
  logic        m_valid, m_err, m_halted;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_BOOT; m_pc = 32'h0; m_valid = 1'b0; m_bpc = 32'h0;
      m_binstr = 32'h0; m_err = 1'b0; m_halted = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_mode == M_BOOT) begin
        m_mode = M_RUN;
      end else if (redirect_valid) begin
        m_pc    = redirect_pc & ~32'h3;
        m_valid = 1'b0;
        m_err   = redirect_pc[1:0] != 2'b00;
        m_mode  = M_RUN;
      end else begin
        if (m_valid && id_ready) m_valid = 1'b0;
        if (m_mode == M_RUN && halt_req) begin
          m_mode = M_HALT;
        end else if (m_mode == M_HALT) begin
          if (!halt_req) m_mode = M_RUN;
        end else if (!m_valid) begin
          m_valid  = 1'b1;
          m_bpc    = m_pc;
          m_binstr = word_at(m_pc);
          m_err    = (m_pc >> 2) >= 32'd64;
          m_pc     = m_pc + 32'd4;
        end
      end
      m_halted = (m_mode == M_HALT) && !m_valid;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_valid", {31'b0, id_valid}, {31'b0, m_valid});
      check("m_err", {31'b0, fetch_err}, {31'b0, m_err});
      check("m_halted", {31'b0, halted}, {31'b0, m_halted});
      check("m_imem_addr", imem_addr, m_pc >> 2);
      if (m_valid) begin
        check("m_id_pc", id_pc, m_bpc);
        check("m_id_instr", id_instr, m_binstr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'b0, id_valid}, 32'h0);
    check("rst_pc", id_pc, 32'h0);
    check("rst_instr", id_instr, 32'h0);
    check("rst_err", {31'b0, fetch_err}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);

    // Boot and sequential stream.
    rst_n = 1'b1;
    @(negedge clk); check("boot_valid", {31'b0, id_valid}, 32'h0);
    @(negedge clk); check("first_pc", id_pc, 32'h0); check("first_instr", id_instr, 32'h1000_0000);
    @(negedge clk); check("seq_pc4", id_pc, 32'h4); check("seq_instr1", id_instr, 32'h1000_0001);
    @(negedge clk); check("seq_pc8", id_pc, 32'h8);

    // Decode stall for three cycles.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_pc", id_pc, 32'h8);
      check("stall_instr", id_instr, 32'h1000_0002);
      check("stall_imem_addr", imem_addr, 32'h3);
    end
    id_ready = 1'b1;
    @(negedge clk); check("resume_pc", id_pc, 32'hC);

    // Redirect while stalled flushes the bundle.
    id_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h14;
    @(negedge clk); check("flush_valid", {31'b0, id_valid}, 32'h0);
    redirect_valid = 1'b0; id_ready = 1'b1;
    @(negedge clk); check("redir_pc", id_pc, 32'h14); check("redir_instr", id_instr, 32'h1000_0005);

    // Misaligned redirect.
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    @(negedge clk); check("misalign_err", {31'b0, fetch_err}, 32'h1);
    redirect_valid = 1'b0;
    @(negedge clk); check("misalign_err_clr", {31'b0, fetch_err}, 32'h0); check("misalign_pc", id_pc, 32'h4);

    // Running off the end of instruction memory.
    redirect_valid = 1'b1; redirect_pc = 32'hF8;
    @(negedge clk); redirect_valid = 1'b0;
    @(negedge clk); check("edge_pc_f8", id_pc, 32'hF8);
    @(negedge clk); check("edge_pc_fc", id_pc, 32'hFC); check("edge_err_fc", {31'b0, fetch_err}, 32'h0);
    @(negedge clk); check("oob_pc", id_pc, 32'h100); check("oob_instr", id_instr, 32'h13);
    check("oob_err", {31'b0, fetch_err}, 32'h1);
    id_ready = 1'b0;
    @(negedge clk); check("oob_err_pulse", {31'b0, fetch_err}, 32'h0); check("oob_hold", id_pc, 32'h100);
    id_ready = 1'b1;
    @(negedge clk); check("oob_next_pc", id_pc, 32'h104); check("oob_next_instr", id_instr, 32'h13);

    // Halt with a stalled bundle.
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    @(negedge clk); redirect_valid = 1'b0;
    @(negedge clk); check("pre_halt_pc", id_pc, 32'h20);
    halt_req = 1'b1; id_ready = 1'b0;
    @(negedge clk); check("halt_hold_valid", {31'b0, id_valid}, 32'h1); check("halt_hold_halted", {31'b0, halted}, 32'h0);
    @(negedge clk); check("halt_hold_pc", id_pc, 32'h20); check("halt_hold_halted2", {31'b0, halted}, 32'h0);
    id_ready = 1'b1;
    @(negedge clk); check("halted_set", {31'b0, halted}, 32'h1); check("halted_valid", {31'b0, id_valid}, 32'h0);
    @(negedge clk); check("halt_frozen", imem_addr, 32'h9);
    halt_req = 1'b0;
    @(negedge clk); check("unhalt_halted", {31'b0, halted}, 32'h0); check("unhalt_valid", {31'b0, id_valid}, 32'h0);
    @(negedge clk); check("unhalt_pc", id_pc, 32'h24); check("unhalt_instr", id_instr, 32'h1000_0009);

    // Redirect out of HALT wins over a still-asserted halt_req.
    halt_req = 1'b1;
    @(negedge clk); check("halt2_halted", {31'b0, halted}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h30;
    @(negedge clk); check("halt_redir_halted", {31'b0, halted}, 32'h0);
    redirect_valid = 1'b0; halt_req = 1'b0;
    @(negedge clk); check("halt_redir_pc", id_pc, 32'h30); check("halt_redir_instr", id_instr, 32'h1000_000C);

    // Reset mid-stall with a redirect pending.
    id_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1 check("async_valid", {31'b0, id_valid}, 32'h0);
    check("async_pc", id_pc, 32'h0);
    check("async_imem_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; redirect_valid = 1'b0; id_ready = 1'b1;
    @(negedge clk); check("reboot_valid", {31'b0, id_valid}, 32'h0);
    @(negedge clk); check("reboot_pc", id_pc, 32'h0); check("reboot_instr", id_instr, 32'h1000_0000);
    repeat (8) @(negedge clk);
    check("stream_pc", id_pc, 32'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
